// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the Galaga ROM download arbiter.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        BOOT,
        DL,
        HOLD,
        RUN
    } state_t;

    localparam int ROM_BYTES_DEF   = 'h10000;
    localparam int HOLD_CYCLES_DEF = 16;

    // Cycles from game_req to game_valid: address register, ROM, capture register.
    localparam int RD_PIPE_DEPTH = 3;

endpackage

// File: rtl/rom_dl_rdpipe.sv
// Game read return path: valid shift register tracking the ROM latency,
// with squash, plus the game_rdata capture register.
module rom_dl_rdpipe
    import rom_dl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          req,
    input  logic          squash,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic          valid
);

    logic [RD_PIPE_DEPTH-2:0] vld_sr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would collapse the shift stages.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
        end else if (squash) begin
            vld_sr <= '0;
            valid  <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[RD_PIPE_DEPTH-3:0], req};
            valid  <= vld_sr[RD_PIPE_DEPTH-2];
            if (vld_sr[RD_PIPE_DEPTH-2]) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/rom_dl_arbiter.sv
// Single-port ROM owner for the Galaga core: arbitrates HPS download writes
// against game reads and sequences game_reset around downloads.
module rom_dl_arbiter
    import rom_dl_pkg::*;
#(
    parameter int AW          = 17,
    parameter int DW          = 8,
    parameter int ROM_BYTES   = ROM_BYTES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    input  logic          game_req,
    input  logic [AW-1:0] game_addr,
    output logic [DW-1:0] game_rdata,
    output logic          game_valid,
    output logic          game_reset,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          dl_done,
    output logic          dl_oor,
    output logic [AW:0]   dl_count
);

    localparam logic [AW:0] ROM_LIMIT = ROM_BYTES[AW:0];
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [AW:0] COUNT_MAX = '1;

    state_t     state, state_nxt;
    logic [7:0] hold_cnt;
    logic       wr_in_range;
    logic       wr_accept;
    logic       wr_drop;
    logic       rd_accept;
    logic       enter_dl;
    logic       squash;

    // NOTE: the default assignment before the case keeps every path driven,
    // so no latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT: if (dl_active) state_nxt = DL;
            DL:   if (!dl_active) state_nxt = HOLD;
            HOLD: begin
                if (dl_active)           state_nxt = DL;
                else if (hold_cnt == '0) state_nxt = RUN;
            end
            RUN:  if (dl_active) state_nxt = DL;
            default: state_nxt = BOOT;
        endcase
    end

    // Writes are taken only while in DL, including the cycle dl_active falls.
    assign wr_in_range = {1'b0, dl_addr} < ROM_LIMIT;
    assign wr_accept   = (state == DL) && dl_wr && wr_in_range;
    assign wr_drop     = (state == DL) && dl_wr && !wr_in_range;
    assign rd_accept   = (state == RUN) && game_req && !dl_active;
    assign enter_dl    = (state_nxt == DL) && (state != DL);
    assign squash      = (state_nxt != RUN);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BOOT;
            hold_cnt   <= '0;
            game_reset <= 1'b1;
            dl_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            game_reset <= (state_nxt != RUN);
            dl_done    <= (state == HOLD) && (state_nxt == RUN);
            if (state == DL && state_nxt == HOLD) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    // Download owns the port whenever it writes; reads never raise mem_we.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_accept;
            if (wr_accept) begin
                mem_addr  <= dl_addr;
                mem_wdata <= dl_data;
            end else if (rd_accept) begin
                mem_addr <= game_addr;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_count <= '0;
            dl_oor   <= 1'b0;
        end else if (enter_dl) begin
            dl_count <= '0;
            dl_oor   <= 1'b0;
        end else begin
            if (wr_accept && dl_count != COUNT_MAX) begin
                dl_count <= dl_count + (AW+1)'(1);
            end
            if (wr_drop) begin
                dl_oor <= 1'b1;
            end
        end
    end

    rom_dl_rdpipe #(
        .DW (DW)
    ) u_rdpipe (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .req       (rd_accept),
        .squash    (squash),
        .mem_rdata (mem_rdata),
        .rdata     (game_rdata),
        .valid     (game_valid)
    );

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Directed self-checking bench for rom_dl_arbiter with a synchronous ROM model.
module tb_rom_dl_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk_sys;
    logic          reset_n;
    logic          dl_active;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [DW-1:0] dl_data;
    logic          game_req;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_rdata;
    logic          game_valid;
    logic          game_reset;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          dl_done;
    logic          dl_oor;
    logic [AW:0]   dl_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] rom [0:(1<<AW)-1];

    rom_dl_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .ROM_BYTES   ('h10000),
        .HOLD_CYCLES (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .game_req   (game_req),
        .game_addr  (game_addr),
        .game_rdata (game_rdata),
        .game_valid (game_valid),
        .game_reset (game_reset),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dl_done    (dl_done),
        .dl_oor     (dl_oor),
        .dl_count   (dl_count)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port ROM store: data one cycle after address.
    always @(posedge clk_sys) begin
        if (mem_we) rom[mem_addr] <= mem_wdata;
        mem_rdata <= rom[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic dl_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bad_rst, bad_we, bad_vld, bad_hold;
        logic [DW-1:0] bytes_q [4];
        bytes_q[0] = 8'hA5; bytes_q[1] = 8'h5A; bytes_q[2] = 8'hC3; bytes_q[3] = 8'h3C;

        for (int i = 0; i < (1<<AW); i++) rom[i] = '0;
        reset_n   = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        game_req  = 1'b0;
        game_addr = '0;

        // Reset values, observed asynchronously before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst_game_reset", 32'(game_reset), 32'd1);
        check("rst_game_valid", 32'(game_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_dl_count", 32'(dl_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // BOOT: 1000 cycles, no download, stray game_req/dl_wr must be ignored.
        bad_rst = 0; bad_we = 0; bad_vld = 0;
        for (int i = 0; i < 1000; i++) begin
            game_req  = i[0];
            game_addr = AW'(i);
            dl_wr     = i[1];
            dl_addr   = AW'(i);
            tick();
            if (game_reset !== 1'b1) bad_rst++;
            if (mem_we !== 1'b0) bad_we++;
            if (game_valid !== 1'b0) bad_vld++;
        end
        check("boot_reset_held", 32'(bad_rst), 32'd0);
        check("boot_no_we", 32'(bad_we), 32'd0);
        check("boot_no_valid", 32'(bad_vld), 32'd0);
        check("boot_mem_addr", 32'(mem_addr), 32'd0);
        game_req = 1'b0; dl_wr = 1'b0; dl_addr = '0;

        // Download A5,5A,C3,3C to 0..3; the last write coincides with dl_active falling.
        dl_active = 1'b1;
        tick();
        check("dl_entry_count", 32'(dl_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            dl_write(AW'(i), bytes_q[i]);
            tick();
            check("dl_we", 32'(mem_we), 32'd1);
            check("dl_addr", 32'(mem_addr), 32'(i));
            check("dl_wdata", 32'(mem_wdata), 32'(bytes_q[i]));
            dl_wr = 1'b0;
            tick();
            check("dl_we_gap", 32'(mem_we), 32'd0);
        end
        dl_write(AW'(3), bytes_q[3]);
        dl_active = 1'b0;
        tick();
        check("fall_we", 32'(mem_we), 32'd1);
        check("fall_wdata", 32'(mem_wdata), 32'h3C);
        dl_wr = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (game_reset !== 1'b1 || dl_done !== 1'b0) bad_hold++;
        end
        check("hold_reset_high", 32'(bad_hold), 32'd0);
        tick();
        check("hold_end_reset", 32'(game_reset), 32'd0);
        check("hold_end_done", 32'(dl_done), 32'd1);
        check("dl_count_4", 32'(dl_count), 32'd4);
        tick();
        check("done_one_cycle", 32'(dl_done), 32'd0);

        // RUN: back-to-back reads of 0,1,2.
        game_req = 1'b1; game_addr = AW'(0);
        tick();
        check("rd_mem_addr", 32'(mem_addr), 32'd0);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        game_addr = AW'(1);
        tick();
        check("rd_no_valid_t2", 32'(game_valid), 32'd0);
        game_addr = AW'(2);
        tick();
        check("rd0_valid", 32'(game_valid), 32'd1);
        check("rd0_data", 32'(game_rdata), 32'hA5);
        game_req = 1'b0;
        tick();
        check("rd1_valid", 32'(game_valid), 32'd1);
        check("rd1_data", 32'(game_rdata), 32'h5A);
        tick();
        check("rd2_valid", 32'(game_valid), 32'd1);
        check("rd2_data", 32'(game_rdata), 32'hC3);
        tick();
        check("rd_valid_end", 32'(game_valid), 32'd0);
        check("rd_data_held", 32'(game_rdata), 32'hC3);

        // Squash: read at t, dl_active at t+1.
        game_req = 1'b1; game_addr = AW'(1);
        tick();
        game_req = 1'b0; dl_active = 1'b1;
        tick();
        check("sq_reset_rise", 32'(game_reset), 32'd1);
        check("sq_valid_t2", 32'(game_valid), 32'd0);
        tick();
        check("sq_valid_t3", 32'(game_valid), 32'd0);
        check("sq_data_held", 32'(game_rdata), 32'hC3);
        check("sq_count_clr", 32'(dl_count), 32'd0);

        // Out-of-range write dropped, then last in-range byte accepted.
        dl_write(AW'('h10000), 8'hEE);
        tick();
        check("oor_no_we", 32'(mem_we), 32'd0);
        check("oor_flag", 32'(dl_oor), 32'd1);
        check("oor_count", 32'(dl_count), 32'd0);
        dl_write(AW'('h0FFFF), 8'h77);
        tick();
        check("top_we", 32'(mem_we), 32'd1);
        check("top_addr", 32'(mem_addr), 32'h0FFFF);
        check("top_count", 32'(dl_count), 32'd1);
        check("oor_sticky", 32'(dl_oor), 32'd1);
        dl_wr = 1'b0;

        // Briefly into HOLD, then re-download: flag and count clear.
        dl_active = 1'b0;
        tick();
        tick();
        tick();
        dl_active = 1'b1;
        tick();
        check("redl_oor_clr", 32'(dl_oor), 32'd0);
        check("redl_count_clr", 32'(dl_count), 32'd0);
        check("redl_reset", 32'(game_reset), 32'd1);

        // Reset mid-burst, asserted between clock edges.
        dl_write(AW'(5), 8'h11);
        tick();
        check("burst_we", 32'(mem_we), 32'd1);
        dl_write(AW'(6), 8'h22);
        #3 reset_n = 1'b0;
        #1;
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", 32'(mem_wdata), 32'd0);
        check("arst_count", 32'(dl_count), 32'd0);
        check("arst_game_reset", 32'(game_reset), 32'd1);
        dl_wr = 1'b0; dl_active = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_boot", 32'(game_reset), 32'd1);

        // Empty download to reach RUN; ROM contents survive the reset.
        dl_active = 1'b1;
        tick();
        dl_active = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) tick();
        check("empty_dl_run", 32'(game_reset), 32'd0);
        check("empty_dl_count", 32'(dl_count), 32'd0);
        game_req = 1'b1; game_addr = AW'('h0FFFF);
        tick();
        game_addr = AW'(3);
        tick();
        game_req = 1'b0;
        tick();
        check("rdtop_valid", 32'(game_valid), 32'd1);
        check("rdtop_data", 32'(game_rdata), 32'h77);
        tick();
        check("rd3_data", 32'(game_rdata), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
